// File: rtl/rf_pkg.sv
// Shared types and defaults for the parametrised register file.
// Holds the clear-engine state type and the address-width helper.
package rf_pkg;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    localparam int RF_DATA_W = 32;
    localparam int RF_DEPTH  = 32;

    // A single-entry file still needs a one-bit address.
    function automatic int rf_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port of the register file.
// Selects zero, bypassed write data or stored data.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = rf_addr_w(RF_DEPTH),
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic              wr_ok,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    logic              in_range;
    logic              is_zero;
    logic              byp_hit;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] rd_next;

    // Zero register and out-of-range reads win over the bypass path.
    always_comb begin
        in_range = ({1'b0, raddr} < LIMIT);
        is_zero  = (ZERO_REG != 0) && (raddr == '0);
        byp_hit  = (BYPASS != 0) && wr_ok && (raddr == waddr);
        idx      = in_range ? raddr : '0;
        rd_next  = '0;
        if (is_zero || !in_range) begin
            rd_next = '0;
        end else if (byp_hit) begin
            rd_next = wdata;
        end else begin
            rd_next = mem[idx];
        end
    end

    // Read data register; holds when the port is not enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_next;
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with a sequential bulk-clear engine.
// Storage, the write port and the clear FSM live here.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int ADDR_W   = rf_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [NUM_RD-1:0] rd_en,
    input  logic [ADDR_W-1:0] raddr [NUM_RD],
    output logic [DATA_W-1:0] rdata [NUM_RD],
    input  logic              clr_req,
    output logic              busy,
    output logic              wr_err
);

    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    rf_state_t         state;
    logic [ADDR_W-1:0] cnt;

    logic idle;
    logic w_in_range;
    logic wr_zero;
    logic wr_ok;
    logic wr_drop;

    // Write qualification: writes to r0 vanish quietly, others error out.
    always_comb begin
        idle       = (state == RF_IDLE);
        w_in_range = ({1'b0, waddr} < LIMIT);
        wr_zero    = (ZERO_REG != 0) && (waddr == '0);
        wr_ok      = we && idle && w_in_range && !wr_zero;
        wr_drop    = we && (!idle || !w_in_range);
    end

    // Storage: write port plus one cleared entry per cycle while clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_ok) begin
                mem[waddr] <= wdata;
            end
            if (state == RF_CLEAR) begin
                mem[cnt] <= '0;
            end
        end
    end

    // Clear FSM with registered busy and write-error flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RF_IDLE;
            cnt    <= '0;
            busy   <= 1'b0;
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_drop;
            case (state)
                RF_IDLE: begin
                    if (clr_req) begin
                        state <= RF_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (cnt == LAST) begin
                        state <= RF_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RF_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // One independent registered read port per requester.
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        rf_read_port #(
            .DATA_W  (DATA_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W),
            .BYPASS  (BYPASS),
            .ZERO_REG(ZERO_REG)
        ) u_port (
            .clk  (clk),
            .rst  (rst),
            .rd_en(rd_en[g]),
            .raddr(raddr[g]),
            .mem  (mem),
            .wr_ok(wr_ok),
            .waddr(waddr),
            .wdata(wdata),
            .rdata(rdata[g])
        );
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: three configurations share one stimulus stream.
// A = default, B = no bypass, C = depth 24 with three read ports.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic        clr = 1'b0;
    logic [4:0]  waddr = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  en = '0;
    logic [4:0]  ra3 [3];
    logic [4:0]  ra2 [2];
    logic [31:0] rd_a [2];
    logic [31:0] rd_b [2];
    logic [31:0] rd_c [3];
    logic        busy_a, busy_b, busy_c;
    logic        err_a, err_b, err_c;

    int total = 0;
    int bad = 0;

    assign ra2[0] = ra3[0];
    assign ra2[1] = ra3[1];

    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) u_a (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_en(en[1:0]), .raddr(ra2), .rdata(rd_a), .clr_req(clr),
        .busy(busy_a), .wr_err(err_a)
    );

    reg_file_mp #(.BYPASS(0)) u_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_en(en[1:0]), .raddr(ra2), .rdata(rd_b), .clr_req(clr),
        .busy(busy_b), .wr_err(err_b)
    );

    reg_file_mp #(.DEPTH(24), .NUM_RD(3)) u_c (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .rd_en(en), .raddr(ra3), .rdata(rd_c), .clr_req(clr),
        .busy(busy_c), .wr_err(err_c)
    );

    // Reference model: array contents plus "next entry to clear" (-1 = idle).
    logic [31:0] mm [3][32];
    logic [31:0] mrd [3][3];
    int          mdep [3] = '{32, 32, 24};
    int          mnrd [3] = '{2, 2, 3};
    bit          mbyp [3] = '{1'b1, 1'b0, 1'b1};
    int          mpos [3];
    bit          merr [3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic m_reset();
        for (int id = 0; id < 3; id++) begin
            for (int a = 0; a < 32; a++) mm[id][a] = '0;
            for (int p = 0; p < 3; p++) mrd[id][p] = '0;
            mpos[id] = -1;
            merr[id] = 1'b0;
        end
    endtask

    task automatic m_step(input int id);
        bit idle;
        bit acc;
        int wa;
        int ra;
        idle = (mpos[id] < 0);
        wa = int'(waddr);
        merr[id] = we && (!idle || wa >= mdep[id]);
        acc = we && idle && wa < mdep[id] && wa != 0;
        for (int p = 0; p < mnrd[id]; p++) begin
            if (en[p]) begin
                ra = int'(ra3[p]);
                if (ra == 0 || ra >= mdep[id]) mrd[id][p] = '0;
                else if (mbyp[id] && acc && ra == wa) mrd[id][p] = wdata;
                else mrd[id][p] = mm[id][ra];
            end
        end
        if (acc) mm[id][wa] = wdata;
        if (!idle) begin
            mm[id][mpos[id]] = '0;
            mpos[id]++;
            if (mpos[id] == mdep[id]) mpos[id] = -1;
        end else if (clr) begin
            mpos[id] = 0;
        end
    endtask

    function automatic logic [31:0] act_rd(input int id, input int p);
        if (id == 0) return (p == 0) ? rd_a[0] : rd_a[1];
        if (id == 1) return (p == 0) ? rd_b[0] : rd_b[1];
        if (p == 0) return rd_c[0];
        if (p == 1) return rd_c[1];
        return rd_c[2];
    endfunction

    function automatic logic act_busy(input int id);
        return (id == 0) ? busy_a : (id == 1) ? busy_b : busy_c;
    endfunction

    function automatic logic act_err(input int id);
        return (id == 0) ? err_a : (id == 1) ? err_b : err_c;
    endfunction

    task automatic cmp_all();
        for (int id = 0; id < 3; id++) begin
            for (int p = 0; p < mnrd[id]; p++) begin
                chk($sformatf("model%0d.rdata%0d", id, p),
                    act_rd(id, p), mrd[id][p]);
            end
            chk($sformatf("model%0d.busy", id),
                32'(act_busy(id)), 32'(mpos[id] >= 0));
            chk($sformatf("model%0d.wr_err", id),
                32'(act_err(id)), 32'(merr[id]));
        end
    endtask

    // One clock: model the edge, let the DUTs take it, compare after it.
    task automatic step();
        for (int id = 0; id < 3; id++) m_step(id);
        @(posedge clk);
        #1;
        cmp_all();
    endtask

    task automatic quiet();
        we = 1'b0;
        clr = 1'b0;
        en = '0;
    endtask

    typedef struct {
        bit          we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  en;
        logic [4:0]  r0, r1, r2;
        logic [31:0] a0, a1, b0, b1, c0;
        bit          ea, ec;
    } vec_t;

    vec_t tv [10];

    initial begin
        int cnt_a;
        int cnt_c;

        tv[0] = '{0, 5'd0,  32'h0,        3'b011, 5'd5, 5'd17, 5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
        tv[1] = '{1, 5'd7,  32'hDEADBEEF, 3'b000, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
        tv[2] = '{0, 5'd0,  32'h0,        3'b001, 5'd7, 5'd0, 5'd0,
                  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0,
                  32'hDEADBEEF, 0, 0};
        tv[3] = '{1, 5'd0,  32'h1234,     3'b000, 5'd0, 5'd0, 5'd0,
                  32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0,
                  32'hDEADBEEF, 0, 0};
        tv[4] = '{0, 5'd0,  32'h0,        3'b001, 5'd0, 5'd0, 5'd0,
                  32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0};
        tv[5] = '{1, 5'd3,  32'hA5A5A5A5, 3'b011, 5'd3, 5'd3, 5'd0,
                  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0,
                  32'hA5A5A5A5, 0, 0};
        tv[6] = '{1, 5'd30, 32'h55,       3'b000, 5'd0, 5'd0, 5'd0,
                  32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0,
                  32'hA5A5A5A5, 0, 1};
        tv[7] = '{0, 5'd0,  32'h0,        3'b111, 5'd30, 5'd30, 5'd30,
                  32'h55, 32'h55, 32'h55, 32'h55, 32'h0, 0, 0};
        tv[8] = '{1, 5'd5,  32'h77,       3'b000, 5'd0, 5'd0, 5'd0,
                  32'h55, 32'h55, 32'h55, 32'h55, 32'h0, 0, 0};
        tv[9] = '{0, 5'd0,  32'h0,        3'b111, 5'd5, 5'd5, 5'd5,
                  32'h77, 32'h77, 32'h77, 32'h77, 32'h77, 0, 0};

        for (int p = 0; p < 3; p++) ra3[p] = '0;
        ra3[0] = 5'd5;
        ra3[1] = 5'd17;

        // Asynchronous reset pulse between clock edges.
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_busy", 32'(busy_a), 32'h0);
        chk("reset_wr_err", 32'(err_a), 32'h0);
        chk("reset_rdata0", rd_a[0], 32'h0);
        chk("reset_rdata1", rd_a[1], 32'h0);
        chk("reset_busy_c", 32'(busy_c), 32'h0);
        m_reset();
        #1 rst = 1'b0;

        // Directed vectors: reads, zero register, bypass, depth 24.
        for (int i = 0; i < 10; i++) begin
            we = tv[i].we;
            waddr = tv[i].wa;
            wdata = tv[i].wd;
            en = tv[i].en;
            ra3[0] = tv[i].r0;
            ra3[1] = tv[i].r1;
            ra3[2] = tv[i].r2;
            clr = 1'b0;
            step();
            chk($sformatf("vec%0d.a_rdata0", i), rd_a[0], tv[i].a0);
            chk($sformatf("vec%0d.a_rdata1", i), rd_a[1], tv[i].a1);
            chk($sformatf("vec%0d.b_rdata0", i), rd_b[0], tv[i].b0);
            chk($sformatf("vec%0d.b_rdata1", i), rd_b[1], tv[i].b1);
            chk($sformatf("vec%0d.c_rdata0", i), rd_c[0], tv[i].c0);
            chk($sformatf("vec%0d.a_wr_err", i), 32'(err_a), 32'(tv[i].ea));
            chk($sformatf("vec%0d.c_wr_err", i), 32'(err_c), 32'(tv[i].ec));
        end
        quiet();

        // Bulk clear after filling every register with its index.
        for (int r = 1; r < 32; r++) begin
            we = 1'b1;
            waddr = 5'(r);
            wdata = 32'(r);
            step();
        end
        quiet();
        clr = 1'b1;
        step();
        clr = 1'b0;
        cnt_a = int'(busy_a);
        cnt_c = int'(busy_c);
        for (int k = 0; k < 60; k++) begin
            if (!busy_a && !busy_c) break;
            if (k == 5) begin
                we = 1'b1;
                waddr = 5'd9;
                wdata = 32'd99;
            end
            step();
            we = 1'b0;
            if (k == 5) chk("clear_write_err", 32'(err_a), 32'h1);
            if (k == 6) chk("clear_write_err_pulse", 32'(err_a), 32'h0);
            cnt_a += int'(busy_a);
            cnt_c += int'(busy_c);
        end
        chk("clear_timeout", 32'(busy_a | busy_c), 32'h0);
        chk("busy_len_a", 32'(cnt_a), 32'd32);
        chk("busy_len_c", 32'(cnt_c), 32'd24);
        for (int a = 0; a < 32; a++) begin
            en = 3'b111;
            for (int p = 0; p < 3; p++) ra3[p] = 5'(a);
            step();
            chk($sformatf("cleared_r%0d", a), rd_a[0], 32'h0);
        end
        quiet();

        // Reset in the middle of a clear.
        we = 1'b1;
        waddr = 5'd20;
        wdata = 32'hFFFF;
        step();
        waddr = 5'd22;
        step();
        quiet();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (10) step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midclr_rst_busy_a", 32'(busy_a), 32'h0);
        chk("midclr_rst_busy_c", 32'(busy_c), 32'h0);
        m_reset();
        #1 rst = 1'b0;
        en = 3'b111;
        ra3[0] = 5'd20;
        ra3[1] = 5'd22;
        ra3[2] = 5'd22;
        step();
        chk("midclr_r20", rd_a[0], 32'h0);
        chk("midclr_r22", rd_a[1], 32'h0);
        quiet();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("reclear_busy", 32'(busy_a), 32'h1);
        repeat (32) step();
        chk("reclear_done", 32'(busy_a), 32'h0);

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            clr = ($urandom_range(0, 39) == 0);
            en = 3'($urandom_range(0, 7));
            for (int p = 0; p < 3; p++) ra3[p] = 5'($urandom_range(0, 31));
            step();
        end
        quiet();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-read-port register file for the RV32 datapath. It replaces the fixed 32x32, two-read, negedge-write register bank. Features:
- Configurable width, depth and read-port count.
- Registered reads with optional write-to-read bypass.
- Hardwired zero register.
- Sequential bulk-clear engine with a busy flag, so the pipeline can flush architectural state without a global reset.

It sits between decode (read addresses) and writeback (write port).

Parameters:
DATA_W, 32, bit width of each register
DEPTH, 32, number of registers (need not be a power of two)
NUM_RD, 2, number of independent read ports
BYPASS, 1, 1 = a same-cycle write to a read address is forwarded to rdata
ZERO_REG, 1, 1 = register 0 reads as zero and ignores writes
ADDR_W, $clog2(DEPTH), address width (derived)

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
rd_en  in  NUM_RD  per-port read enable
raddr  in  NUM_RD x ADDR_W  per-port read address (unpacked array)
rdata  out  NUM_RD x DATA_W  per-port registered read data (unpacked array)
clr_req  in  1  single-cycle pulse requesting a bulk clear
busy  out  1  high while the clear engine runs
wr_err  out  1  one-cycle pulse: a write was dropped (out of range, or during clear)

Behaviour:
- Reset (async, rst=1): all storage entries 0, all rdata 0, busy 0, wr_err 0, FSM in IDLE, clear counter 0. Effect is immediate, not clock-gated.
- Write: on posedge, when we=1, state=IDLE and waddr<DEPTH, entry[waddr] <= wdata.
  - If ZERO_REG=1 and waddr=0, the write is silently discarded; wr_err is NOT raised.
- Read: 1-cycle latency.
  - If rd_en[i]=1 at posedge N, rdata[i] after edge N = entry[raddr[i]] as stored before edge N.
  - If rd_en[i]=0, rdata[i] holds its previous value.
- Bypass:
  - BYPASS=1, we=1, write accepted, rd_en[i]=1 and raddr[i]=waddr in the same cycle: rdata[i] gets wdata.
  - BYPASS=0: rdata[i] gets the old value.
- Zero register: ZERO_REG=1 and raddr[i]=0 gives rdata[i]=0, regardless of bypass.
- Out of range (raddr[i]>=DEPTH): rdata[i] <= 0.
- All read ports are independent; any number may hit the same address.
- Clear FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR on posedge with clr_req=1. Counter <= 0; busy=1 from the next cycle.
  - CLEAR: each cycle entry[cnt] <= 0, cnt++. On cnt=DEPTH-1, write the last entry and return to IDLE. busy drops the cycle after the last clear write.
  - Total busy time = DEPTH cycles.
  - clr_req in CLEAR is ignored; it is not queued.
- Writes during CLEAR (we=1): dropped, wr_err=1 for one cycle.
- Reads during CLEAR: permitted; they return current storage (already-cleared entries read 0). No bypass from the clear engine.
- Same-cycle we and clr_req in IDLE: the write is accepted, then the clear begins and zeroes it.
- Out-of-range write: dropped, wr_err=1 for one cycle.
- wr_err is registered and cleared the next cycle unless re-triggered.
- Reset mid-clear: immediate return to IDLE with all entries 0.

Decomposition:
- Package rf_pkg holds:
  - typedef enum logic {RF_IDLE, RF_CLEAR} rf_state_t
  - default localparams RF_DATA_W=32 and RF_DEPTH=32
  - function rf_addr_w(depth) returning the address width
- One sub-module, rf_read_port: a single registered read port containing the zero, out-of-range and bypass mux. It is instantiated NUM_RD times by a generate loop.
- Storage, write logic and the clear FSM stay in the top module.

Test Plan:
1. Reset then read. Assert rst mid-cycle with no clock edge, then release; rd_en=2'b11, raddr={5,17} -> rdata={0,0}; busy=0, wr_err=0.
2. Write then read, plus zero register. Write 0xDEADBEEF to r7, then read port0 r7 one cycle later -> rdata[0]=0xDEADBEEF. Write 0x1234 to r0, then read r0 -> 0.
3. Bypass. Same cycle: we=1, waddr=3, wdata=0xA5A5A5A5, raddr[0]=raddr[1]=3 -> both rdata=0xA5A5A5A5 next cycle. Rerun with BYPASS=0 -> both rdata = prior value 0.
4. Bulk clear. Fill r1..r31 with their index, then pulse clr_req.
   - busy is high for exactly 32 cycles.
   - A write to r9 during busy raises wr_err for 1 cycle.
   - After busy falls, reading all addresses gives 0.
5. Reset mid-clear. Pulse clr_req, wait 10 cycles, assert rst -> busy=0 immediately; after release, all entries read 0 and a new clr_req is accepted.
6. Non-power-of-two depth. With DEPTH=24 and NUM_RD=3:
   - Write to address 30 -> wr_err=1, no storage change.
   - Read address 30 -> 0.
   - Three ports reading r5 concurrently all return the same value.
